// File: rtl/hc161_timer_ctrl.sv
// Sequencer for a cascaded 74x161 counter chain: preset load, count gating, tick/done generation.
// Optional interrupt output enabled by defining HC161_TIMER_IRQ_EN.
module hc161_timer_ctrl #(
  parameter  int STAGES = 2,
  parameter  int TCNT_W = 8,
  localparam int W      = 4 * STAGES
) (
  input  logic              CP,
  input  logic              MR_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              mode,
  input  logic [W-1:0]      period,
  input  logic              tc,
  output logic              pe_n,
  output logic              cep_n,
  output logic              cet_n,
  output logic [W-1:0]      d,
  output logic              busy,
  output logic              tick,
  output logic              done,
  output logic [TCNT_W-1:0] tick_cnt,
  output logic              cfg_err
`ifdef HC161_TIMER_IRQ_EN
  ,
  input  logic              irq_clr,
  output logic              irq
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic                r_mode;
  logic [W-1:0]        r_preset;
  logic                r_busy;
  logic [TCNT_W-1:0]   r_tick_cnt;
  logic                r_cfg_err;

  logic                w_accept;
  logic                w_evt;

  // The chain counts up from the preset and raises tc at all-ones, so the preset is -max(P,2).
  function automatic logic [W-1:0] preset_of(input logic [W-1:0] p);
    logic [W-1:0] pe;
    pe = (p < W'(2)) ? W'(2) : p;
    return (~pe) + W'(1);
  endfunction

  assign w_accept = (r_state == S_IDLE) && start && !stop;
  assign w_evt    = (r_state == S_RUN) && tc && !pause && !stop;

  assign tick     = w_evt;
  assign done     = (r_state == S_DONE) && !stop;
  // Auto-reload pulls pe_n low in the terminal-count cycle so the reload costs no extra cycle.
  assign pe_n     = !(((r_state == S_LOAD) && !stop) || (w_evt && r_mode));
  assign cep_n    = !((r_state == S_RUN) && !pause && !stop);
  assign cet_n    = (r_state != S_RUN);
  assign d        = r_preset;
  assign busy     = r_busy;
  assign tick_cnt = r_tick_cnt;
  assign cfg_err  = r_cfg_err;

  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_preset   <= '0;
      r_busy     <= 1'b0;
      r_tick_cnt <= '0;
      r_cfg_err  <= 1'b0;
    end else if (stop) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_mode     <= mode;
            r_preset   <= preset_of(period);
            r_tick_cnt <= '0;
            r_cfg_err  <= (period < W'(2));
          end
        end
        S_LOAD: begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
        end
        S_RUN: begin
          if (w_evt) begin
            r_tick_cnt <= r_tick_cnt + TCNT_W'(1);
            if (!r_mode) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HC161_TIMER_IRQ_EN
  logic r_irq;

  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n)
      r_irq <= 1'b0;
    else if (tick || done)
      r_irq <= 1'b1;
    else if (irq_clr)
      r_irq <= 1'b0;
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_hc161_timer_ctrl.sv
// Directed bench for hc161_timer_ctrl with a behavioural single-stage 161 chain model.
module tb_hc161_timer_ctrl;
  localparam int STAGES = 1;
  localparam int TCNT_W = 8;
  localparam int W      = 4 * STAGES;

  logic              CP = 1'b0;
  logic              MR_n;
  logic              start, stop, pause, mode, tc;
  logic [W-1:0]      period;
  logic              pe_n, cep_n, cet_n, busy, tick, done, cfg_err;
  logic [W-1:0]      d;
  logic [TCNT_W-1:0] tick_cnt;
`ifdef HC161_TIMER_IRQ_EN
  logic              irq_clr, irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hc161_timer_ctrl #(.STAGES(STAGES), .TCNT_W(TCNT_W)) dut (
    .CP(CP), .MR_n(MR_n), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .period(period), .tc(tc), .pe_n(pe_n), .cep_n(cep_n),
    .cet_n(cet_n), .d(d), .busy(busy), .tick(tick), .done(done),
    .tick_cnt(tick_cnt), .cfg_err(cfg_err)
`ifdef HC161_TIMER_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq)
`endif
  );

  always #5 CP = ~CP;

  logic [W-1:0] chain;
  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n)                chain <= '0;
    else if (!pe_n)           chain <= d;
    else if (!cep_n && !cet_n) chain <= chain + W'(1);
  end
  assign tc = (&chain) && !cet_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CP);
    #1;
  endtask

  // Leaves the DUT in LOAD, one time unit after the edge.
  task automatic begin_op(input logic m, input logic [W-1:0] p);
    start  = 1'b1;
    mode   = m;
    period = p;
    #1;
    cyc();
    start = 1'b0;
  endtask

  task automatic stop_op();
    stop = 1'b1;
    #1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    MR_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; period = '0;
`ifdef HC161_TIMER_IRQ_EN
    irq_clr = 1'b0;
`endif
    #2;
    check("rst_pe_n", pe_n, 1);
    check("rst_cep_n", cep_n, 1);
    check("rst_cet_n", cet_n, 1);
    check("rst_d", d, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", tick, 0);
    check("rst_done", done, 0);
    check("rst_tick_cnt", tick_cnt, 0);
    check("rst_cfg_err", cfg_err, 0);
    #10 MR_n = 1'b1;
    cyc();

    // 1: auto-reload, P=5
    begin_op(1'b1, 4'd5);
    #1;
    check("t1_load_pe_n", pe_n, 0);
    check("t1_load_d", d, 11);
    check("t1_load_busy", busy, 1);
    check("t1_load_cep_n", cep_n, 1);
    cyc();
    for (int i = 1; i <= 15; i++) begin
      #1;
      check("t1_tick", tick, (i % 5) == 0);
      check("t1_tick_cnt", tick_cnt, (i - 1) / 5);
      cyc();
    end
    #1;
    check("t1_tick_cnt_end", tick_cnt, 3);
    stop = 1'b1;
    #1;
    check("t1_stop_cep_n", cep_n, 1);
    cyc();
    stop = 1'b0;
    #1;
    check("t1_idle_busy", busy, 0);

    // 2: one-shot, P=3
    begin_op(1'b0, 4'd3);
    cyc();
    for (int i = 1; i <= 3; i++) begin
      #1;
      check("t2_tick", tick, i == 3);
      check("t2_done_run", done, 0);
      cyc();
    end
    #1;
    check("t2_done", done, 1);
    check("t2_done_tick", tick, 0);
    check("t2_done_busy", busy, 0);
    check("t2_tick_cnt", tick_cnt, 1);
    cyc();
    #1;
    check("t2_idle_busy", busy, 0);
    check("t2_idle_pe_n", pe_n, 1);
    check("t2_idle_cep_n", cep_n, 1);
    check("t2_idle_cet_n", cet_n, 1);
    check("t2_idle_done", done, 0);

    // 3: pause mid-period, then pause while tc is high
    begin_op(1'b1, 4'd4);
    cyc();
    for (int i = 1; i <= 13; i++) begin
      pause = ((i >= 2) && (i <= 4)) || (i == 11) || (i == 12);
      #1;
      check("t3_tick", tick, (i == 7) || (i == 13));
      check("t3_cep_n", cep_n, pause);
      check("t3_cet_n", cet_n, 0);
      cyc();
    end
    pause = 1'b0;
    stop_op();

    // 4: stop in the terminal-count cycle of a one-shot
    begin_op(1'b0, 4'd3);
    cyc();
    cyc();
    cyc();
    stop = 1'b1;
    #1;
    check("t4_tc", tc, 1);
    check("t4_tick", tick, 0);
    check("t4_done", done, 0);
    check("t4_pe_n", pe_n, 1);
    check("t4_cep_n", cep_n, 1);
    cyc();
    stop = 1'b0;
    #1;
    check("t4_busy", busy, 0);
    check("t4_done_after", done, 0);
    check("t4_tick_cnt", tick_cnt, 0);

    // 5: P=0 clamps to 2 and flags cfg_err; start+stop together; start ignored in RUN
    begin_op(1'b1, 4'd0);
    #1;
    check("t5_cfg_err", cfg_err, 1);
    check("t5_d", d, 14);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("t5_tick", tick, (i % 2) == 0);
      cyc();
    end
    stop_op();
    start = 1'b1; stop = 1'b1; period = 4'd6;
    #1;
    cyc();
    start = 1'b0; stop = 1'b0;
    #1;
    check("t5_ss_busy", busy, 0);
    check("t5_ss_pe_n", pe_n, 1);
    check("t5_ss_cfg_err", cfg_err, 1);
    begin_op(1'b0, 4'd6);
    #1;
    check("t5_cfg_err_clr", cfg_err, 0);
    check("t5_d6", d, 10);
    cyc();
    period = 4'd3;
    for (int i = 1; i <= 6; i++) begin
      start = (i <= 5);
      #1;
      check("t5_tick6", tick, i == 6);
      cyc();
    end
    start = 1'b0;
    #1;
    check("t5_done6", done, 1);
    cyc();

    // 6: asynchronous reset mid-RUN
    begin_op(1'b1, 4'd4);
    cyc();
    for (int i = 1; i <= 5; i++) begin
      #1;
      check("t6_tick", tick, i == 4);
      cyc();
    end
    #1;
    check("t6_tick_cnt_pre", tick_cnt, 1);
`ifdef HC161_TIMER_IRQ_EN
    check("t6_irq_pre", irq, 1);
`endif
    MR_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pe_n", pe_n, 1);
    check("t6_rst_cep_n", cep_n, 1);
    check("t6_rst_cet_n", cet_n, 1);
    check("t6_rst_d", d, 0);
    check("t6_rst_tick", tick, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_tick_cnt", tick_cnt, 0);
`ifdef HC161_TIMER_IRQ_EN
    check("t6_rst_irq", irq, 0);
`endif
    MR_n = 1'b1;
    cyc();
    #1;
    check("t6_after_busy", busy, 0);
    begin_op(1'b1, 4'd2);
    cyc();
    cyc();
    #1;
    check("t6_tick2", tick, 1);
    cyc();
`ifdef HC161_TIMER_IRQ_EN
    check("t6_irq_set", irq, 1);
    irq_clr = 1'b1;
`endif
    #1;
    cyc();
    #1;
    check("t6_tick4", tick, 1);
`ifdef HC161_TIMER_IRQ_EN
    check("t6_irq_clr", irq, 0);
`endif
    cyc();
`ifdef HC161_TIMER_IRQ_EN
    irq_clr = 1'b0;
    check("t6_irq_set_wins", irq, 1);
`endif
    stop_op();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
